// File: rtl/instr_encoder.sv
// Symbolic-instruction to MIPS machine-word encoder with a valid/ready output stream.
// The pseudo-instruction li expands into lui+ori when its upper half is nonzero.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [0:0] {IDLE, LI2} state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_word_q, out_word_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         li_rt_q, li_rt_d;
  logic [15:0]        li_lo_q, li_lo_d;

  logic               slot_free;
  logic               accept;
  logic               drain;
  logic [31:0]        enc_word;
  logic               enc_legal;
  logic               li_split;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  assign drain     = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = reset_n && (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    li_split  = 1'b0;
    case (in_kind)
      5'd0:  enc_word = 32'h0;
      5'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      5'd2:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      5'd3:  enc_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      5'd4:  enc_word = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h09};
      5'd5:  enc_word = itype(6'h0D, in_rs, in_rt, in_imm[15:0]);
      5'd6:  enc_word = itype(6'h23, in_rs, in_rt, in_imm[15:0]);
      5'd7:  enc_word = itype(6'h2B, in_rs, in_rt, in_imm[15:0]);
      5'd8:  enc_word = itype(6'h04, in_rs, in_rt, in_imm[15:0]);
      5'd9:  enc_word = itype(6'h0F, 5'd0, in_rt, in_imm[15:0]);
      5'd10: enc_word = {6'h02, in_imm[27:2]};
      5'd11: enc_word = {6'h03, in_imm[27:2]};
      5'd12: enc_word = itype(6'h20, in_rs, in_rt, in_imm[15:0]);
      5'd13: enc_word = itype(6'h28, in_rs, in_rt, in_imm[15:0]);
      5'd14: enc_word = itype(6'h21, in_rs, in_rt, in_imm[15:0]);
      5'd15: enc_word = itype(6'h29, in_rs, in_rt, in_imm[15:0]);
      5'd16: enc_word = itype(6'h24, in_rs, in_rt, in_imm[15:0]);
      5'd17: enc_word = itype(6'h25, in_rs, in_rt, in_imm[15:0]);
      5'd18: enc_word = itype(6'h2A, in_rs, in_rt, in_imm[15:0]);
      5'd19: enc_word = itype(6'h2E, in_rs, in_rt, in_imm[15:0]);
      5'd20: enc_word = itype(6'h05, in_rs, in_rt, in_imm[15:0]);
      5'd21: enc_word = itype(6'h07, in_rs, 5'd0, in_imm[15:0]);
      5'd22: enc_word = itype(6'h01, in_rs, 5'd0, in_imm[15:0]);
      5'd23: begin
        // A zero upper half lets li collapse into a single ori from $0.
        if (in_imm[31:16] == 16'h0) begin
          enc_word = itype(6'h0D, 5'd0, in_rt, in_imm[15:0]);
        end else begin
          enc_word = itype(6'h0F, 5'd0, in_rt, in_imm[31:16]);
          li_split = 1'b1;
        end
      end
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    li_rt_d     = li_rt_q;
    li_lo_d     = li_lo_q;
    cnt_d       = cnt_q;

    if (drain) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!enc_legal) begin
            err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_word_d  = enc_word;
            out_last_d  = !li_split;
            if (li_split) begin
              state_d = LI2;
              li_rt_d = in_rt;
              li_lo_d = in_imm[15:0];
            end
          end
        end
      end
      LI2: begin
        // The second half comes only from the captured fields, never the live inputs.
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_word_d  = itype(6'h0D, li_rt_q, li_rt_q, li_lo_q);
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      li_rt_q     <= 5'd0;
      li_lo_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      li_rt_q     <= li_rt_d;
      li_lo_q     <= li_lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: each task drives one scenario
// and compares outputs against hand-encoded MIPS words.
module tb_instr_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic        err;
  logic [15:0] word_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm);
    in_valid = 1'b1;
    in_kind  = k;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 5'd0;
    in_rs     = 5'd0;
    in_rt     = 5'd0;
    in_rd     = 5'd0;
    in_imm    = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({out_valid, out_last, err} !== 3'b000) begin
      n_err++;
      $display("[TB] FAIL reset_flags got v/l/e=%b%b%b want 000", out_valid, out_last, err);
    end
    n_vec++;
    if (out_word !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_word got %h want 00000000", out_word);
    end
    n_vec++;
    if (word_cnt !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL reset_cnt got %0d want 0", word_cnt);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
    end
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_addu();
    out_ready = 1'b1;
    drive(5'd1, 5'd1, 5'd2, 5'd3, 32'h0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 32'h00221821 || out_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL addu got v=%b w=%h l=%b want v=1 w=00221821 l=1",
               out_valid, out_word, out_last);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (word_cnt !== exp_cnt) begin
      n_err++;
      $display("[TB] FAIL addu_cnt got %0d want %0d", word_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  k   [8];
    logic [4:0]  rs  [8];
    logic [4:0]  rt  [8];
    logic [4:0]  rd  [8];
    logic [31:0] imm [8];
    logic [31:0] exp [8];
    k[0]=5'd5;  rs[0]=5'd0;  rt[0]=5'd8; rd[0]=5'd0;  imm[0]=32'h00001234; exp[0]=32'h34081234;
    k[1]=5'd7;  rs[1]=5'd29; rt[1]=5'd5; rd[1]=5'd0;  imm[1]=32'h00000008; exp[1]=32'hAFA50008;
    k[2]=5'd10; rs[2]=5'd0;  rt[2]=5'd0; rd[2]=5'd0;  imm[2]=32'h00400010; exp[2]=32'h08100004;
    k[3]=5'd22; rs[3]=5'd4;  rt[3]=5'd0; rd[3]=5'd0;  imm[3]=32'hFFFFFFFF; exp[3]=32'h0480FFFF;
    k[4]=5'd4;  rs[4]=5'd31; rt[4]=5'd7; rd[4]=5'd31; imm[4]=32'h0;        exp[4]=32'h03E0F809;
    k[5]=5'd9;  rs[5]=5'd5;  rt[5]=5'd1; rd[5]=5'd9;  imm[5]=32'h5555ABCD; exp[5]=32'h3C01ABCD;
    k[6]=5'd0;  rs[6]=5'd7;  rt[6]=5'd7; rd[6]=5'd7;  imm[6]=32'hFFFFFFFF; exp[6]=32'h00000000;
    k[7]=5'd21; rs[7]=5'd2;  rt[7]=5'd9; rd[7]=5'd3;  imm[7]=32'hABCD0010; exp[7]=32'h1C400010;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(k[i], rs[i], rt[i], rd[i], imm[i]);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_word !== exp[i] || out_last !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL b2b_word[%0d] got v=%b w=%h l=%b want v=1 w=%h l=1",
                 i, out_valid, out_word, out_last, exp[i]);
      end
      if (i > 0) exp_cnt = exp_cnt + 16'd1;
    end
    in_valid = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (word_cnt !== exp_cnt || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_cnt got cnt=%0d v=%b want cnt=%0d v=0", word_cnt, out_valid, exp_cnt);
    end
  endtask

  task automatic test_li();
    out_ready = 1'b1;
    drive(5'd23, 5'd3, 5'd9, 5'd4, 32'h12345678);
    tick();
    drive(5'd1, 5'd0, 5'd0, 5'd0, 32'h0);
    n_vec++;
    if (out_word !== 32'h3C091234 || out_last !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL li_lui got v=%b w=%h l=%b want v=1 w=3C091234 l=0",
               out_valid, out_word, out_last);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL li2_in_ready got %b want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_word !== 32'h35295678 || out_last !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL li_ori got v=%b w=%h l=%b want v=1 w=35295678 l=1",
               out_valid, out_word, out_last);
    end
    tick();
    exp_cnt = exp_cnt + 16'd2;
    n_vec++;
    if (word_cnt !== exp_cnt || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL li_cnt got cnt=%0d v=%b want cnt=%0d v=0", word_cnt, out_valid, exp_cnt);
    end
    drive(5'd23, 5'd0, 5'd9, 5'd0, 32'h00007FFF);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_word !== 32'h34097FFF || out_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL li_short got w=%h l=%b want w=34097FFF l=1", out_word, out_last);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (word_cnt !== exp_cnt || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL li_short_cnt got cnt=%0d v=%b want cnt=%0d v=0", word_cnt, out_valid, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(5'd6, 5'd3, 5'd2, 5'd0, 32'h00000010);
    tick();
    drive(5'd2, 5'd5, 5'd6, 5'd4, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_word !== 32'h8C620010 || out_last !== 1'b1 ||
          in_ready !== 1'b0 || word_cnt !== exp_cnt) begin
        n_err++;
        $display("[TB] FAIL stall[%0d] got v=%b w=%h l=%b rdy=%b cnt=%0d want v=1 w=8C620010 l=1 rdy=0 cnt=%0d",
                 i, out_valid, out_word, out_last, in_ready, word_cnt, exp_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL release_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (out_word !== 32'h00A62023 || out_valid !== 1'b1 || word_cnt !== exp_cnt) begin
      n_err++;
      $display("[TB] FAIL release_word got w=%h v=%b cnt=%0d want w=00A62023 v=1 cnt=%0d",
               out_word, out_valid, word_cnt, exp_cnt);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(5'd27, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL illegal_err got err=%b v=%b want err=1 v=0", err, out_valid);
    end
    tick();
    n_vec++;
    if (err !== 1'b0 || out_valid !== 1'b0 || word_cnt !== exp_cnt) begin
      n_err++;
      $display("[TB] FAIL illegal_after got err=%b v=%b cnt=%0d want err=0 v=0 cnt=%0d",
               err, out_valid, word_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_in_li();
    out_ready = 1'b1;
    drive(5'd23, 5'd0, 5'd9, 5'd0, 32'h12345678);
    tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_vec++;
    if (out_valid !== 1'b0 || word_cnt !== exp_cnt || in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL li_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=0",
               out_valid, word_cnt, in_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin
        n_err++;
        $display("[TB] FAIL li_reset_no_ori[%0d] got v=%b w=%h cnt=%0d want v=0 cnt=0",
                 i, out_valid, out_word, word_cnt);
      end
    end
    drive(5'd1, 5'd1, 5'd2, 5'd3, 32'h0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 32'h00221821 || out_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL post_reset_addu got v=%b w=%h l=%b want v=1 w=00221821 l=1",
               out_valid, out_word, out_last);
    end
    tick();
    n_vec++;
    if (word_cnt !== 16'd1) begin
      n_err++;
      $display("[TB] FAIL post_reset_cnt got %0d want 1", word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_back_to_back();
    test_li();
    test_backpressure();
    test_illegal();
    test_reset_in_li();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the CPU decode stage: turns a symbolic instruction (mnemonic code plus register and immediate fields) into 32-bit MIPS machine words.
- Streams the words out over a valid/ready handshake.
- Used by bench-side program generators and the on-chip loader feeding instruction memory.
- Expands the pseudo-instruction li into lui+ori via a small FSM.
- Keeps a running count of emitted words.

Parameters:
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  encoder accepts request this cycle
- in_kind  input  5  mnemonic code: 0 nop, 1 addu, 2 subu, 3 jr, 4 jalr, 5 ori, 6 lw, 7 sw, 8 beq, 9 lui, 10 j, 11 jal, 12 lb, 13 sb, 14 lh, 15 sh, 16 lbu, 17 lhu, 18 swl, 19 swr, 20 bne, 21 bgtz, 22 bltz, 23 li; 24-31 illegal
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  32  immediate / byte target / word offset
- out_valid  output  1  out_word valid
- out_ready  input  1  consumer takes word
- out_word  output  32  encoded instruction
- out_last  output  1  word is final word of its request
- err  output  1  one-cycle pulse: illegal in_kind accepted
- word_cnt  output  CNT_W  words emitted (handshakes completed), wraps

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, out_word=0, out_last=0, err=0, word_cnt=0. in_ready=0 while reset_n=0. A reset asserted mid-li discards the pending ori word.
- Output slot: one register. It is "free" when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- in_ready = (state==IDLE) and slot free. Purely combinational from registered state and out_ready; no dependency on in_valid.
- Accept = in_valid & in_ready. On accept, the encoded word loads next cycle; output latency is 1 cycle.
- Field packing:
  - R-type: op=0, {rs,rt,rd,shamt=0,funct}. Funct: addu 0x21, subu 0x23, jr 0x08 (rt=rd=0), jalr 0x09 (rt=0).
  - I-type: {op,rs,rt,imm[15:0]}. Opcodes: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, lui 0x0F (rs=0), lb 0x20, sb 0x28, lh 0x21, sh 0x29, lbu 0x24, lhu 0x25, swl 0x2A, swr 0x2E.
  - bgtz: op 0x07, rt=0. bltz: op 0x01, rt=0. Branch imm is the word offset, taken as in_imm[15:0].
  - j 0x02 / jal 0x03: {op, in_imm[27:2]}. in_imm[1:0] and in_imm[31:28] are ignored.
  - nop: 0x00000000.
  - All unused fields are forced to 0 regardless of inputs.
- li:
  - If in_imm[31:16]==0, emit the single word ori rt,$0,imm[15:0] with out_last=1.
  - Otherwise emit lui rt,imm[31:16] with out_last=0 and go to LI2. In LI2, in_ready=0. When the slot is free, load ori rt,rt,imm[15:0] with out_last=1 and return to IDLE.
  - rt and imm are held in internal registers, not re-sampled from the inputs.
- Illegal kind: accepted, no word emitted, err=1 for exactly the next cycle. out_valid is unchanged by the illegal request.
- All other kinds set out_last=1.
- out_word, out_valid and out_last are stable while out_valid=1 and out_ready=0.
- word_cnt increments on each out_valid&out_ready and wraps at 2^CNT_W.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, so back-to-back throughput is 1 word/cycle.

Test Plan:
- Reset, then addu rd=3 rs=1 rt=2, out_ready=1 -> out_word=0x00221821, out_last=1 one cycle after accept, word_cnt=1.
- ori rt=8 rs=0 imm=0x1234; sw rt=5 rs=29 imm=8; j imm=0x00400010; bltz rs=4 imm=0xFFFFFFFF back-to-back -> 0x34081234, 0xAFA50008, 0x08100004, 0x0480FFFF on consecutive cycles; in_ready held 1.
- li rt=9 imm=0x12345678 -> 0x3C091234 (last=0), then 0x35295678 (last=1); in_ready=0 during LI2. li rt=9 imm=0x00007FFF -> single 0x34097FFF.
- Backpressure: out_ready=0 for 5 cycles with a word pending -> out_word stable, in_ready=0, word_cnt unchanged; release -> drains, next request accepted the same cycle.
- in_kind=27 -> err pulse of 1 cycle, out_valid stays 0, word_cnt unchanged.
- reset_n low in LI2 after lui is emitted -> out_valid=0 immediately, ori never appears, word_cnt=0; after release an addu encodes normally.
